aes_inv_cipher: RTL and testbench

- Iterative AES-128 decryption core. Processes one inverse round per clock.
- Generates the inverse key schedule on the fly from the round-10 key, so no stored key table is needed.
- Sits at the receive end of the Rijndael datapath, as the counterpart of the encrypt-side round/addKey chain.
- AddRoundKey reuses the existing addKey block (keyedOut = keyedIn ^ key).

---
 rtl/aes_inv_cipher.sv | 202 ++++++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, with the inverse
// key schedule stepped backwards on the fly from the round-10 key.
module aes_inv_cipher #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] cipherIn,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plainOut
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] plain_q, plain_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] rk_next;
   logic [127:0] keyed;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; zero maps to zero as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = x;
      res = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] i;
      i = gf_inv(x);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte n = row + 4*col lives at bits [127-8n -: 8].
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-32*c-8*row -: 8] = s[127-32*((c-row+4)%4)-8*row -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int n = 0; n < 16; n++) r[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return r;
   endfunction

   // Undo one forward expansion step: recover round key i-1 from round key i.
   function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]   ^ k[63:32];
      w2 = k[63:32]  ^ k[95:64];
      w1 = k[95:64]  ^ k[127:96];
      w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] rc);
      return (rc == 8'h1b) ? 8'h80 : (rc >> 1);
   endfunction

   // Same behaviour as the encrypt-side addKey block: keyedOut = keyedIn ^ key.
   function automatic logic [127:0] add_key(input logic [127:0] keyed_in, input logic [127:0] k);
      return keyed_in ^ k;
   endfunction

   assign rk_next   = inv_key_step(rk_q, rcon_q);
   assign keyed     = add_key(inv_sub_bytes(inv_shift_rows(st_q)), rk_next);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign plainOut  = plain_q;

   always_comb begin
      // NOTE: every next-state signal is defaulted to its current value first, so no
      // path through the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      st_d        = st_q;
      rk_d        = rk_q;
      rnd_d       = rnd_q;
      rcon_d      = rcon_q;
      plain_d     = plain_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = add_key(cipherIn, key);
               rk_d    = key;
               rnd_d   = 4'(NR - 1);
               rcon_d  = 8'h36;
               state_d = ROUND;
            end
         end
         ROUND: begin
            rk_d   = rk_next;
            rnd_d  = rnd_q - 4'd1;
            rcon_d = inv_xtime(rcon_q);
            if (rnd_q == 4'd0) begin
               plain_d     = keyed;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               st_d = inv_mix_columns(keyed);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every register samples
      // the pre-edge values; reset is synchronous, so it is tested inside the clocked block.
      if (!rst_n) begin
         state_q     <= IDLE;
         st_q        <= '0;
         rk_q        <= '0;
         rnd_q       <= '0;
         rcon_q      <= '0;
         plain_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         rk_q        <= rk_d;
         rnd_q       <= rnd_d;
         rcon_q      <= rcon_d;
         plain_q     <= plain_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed FIPS-197 vectors for aes_inv_cipher: latency, internal key schedule,
// back-pressure, mid-operation reset and back-to-back handshakes.
module tb_aes_inv_cipher;

   localparam logic [127:0] B_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
   localparam logic [127:0] B_KEY = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] B_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] B_K1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
   localparam logic [127:0] B_R1  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] C_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
   localparam logic [127:0] C_KEY = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;
   localparam logic [127:0] C_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] cipherIn;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plainOut;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   aes_inv_cipher dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .cipherIn (cipherIn),
      .key      (key),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .plainOut (plainOut)
   );

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts rising edges until out_valid is seen; -1 if it never appears.
   task automatic wait_valid(output int edges);
      edges = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (out_valid) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cipherIn = '0; key = '0;
      tick(); tick();
      rst_n = 1'b1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (plainOut !== 128'h0) begin n_bad++; $display("FAIL reset_plainOut got %h want 0", plainOut); end
   endtask

   task automatic test_fips_b();
      int first_valid;
      first_valid = 0;
      out_ready = 1'b1;
      cipherIn = B_CT; key = B_KEY; in_valid = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         tick();
         if (e == 1) begin
            in_valid = 1'b0; cipherIn = '0; key = '0;
         end
         if (out_valid && first_valid == 0) first_valid = e;
         if (e == 9) begin
            n_cmp++; if (dut.rnd_q !== 4'd1) begin n_bad++; $display("FAIL b_rnd_at_edge9 got %0d want 1", dut.rnd_q); end
            n_cmp++; if (dut.keyed !== B_R1) begin n_bad++; $display("FAIL b_round1_addkey got %h want %h", dut.keyed, B_R1); end
         end
         if (e == 10) begin
            n_cmp++; if (dut.rk_q !== B_K1) begin n_bad++; $display("FAIL b_round_key1 got %h want %h", dut.rk_q, B_K1); end
         end
      end
      n_cmp++; if (first_valid !== 11) begin n_bad++; $display("FAIL b_latency got %0d want 11", first_valid); end
      n_cmp++; if (plainOut !== B_PT) begin n_bad++; $display("FAIL b_plain got %h want %h", plainOut, B_PT); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL b_handshake got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
   endtask

   task automatic test_fips_c1();
      int edges;
      out_ready = 1'b1;
      cipherIn = C_CT; key = C_KEY; in_valid = 1'b1;
      wait_valid(edges);
      in_valid = 1'b0;
      n_cmp++; if (edges !== 11) begin n_bad++; $display("FAIL c1_latency got %0d want 11", edges); end
      n_cmp++; if (plainOut !== C_PT) begin n_bad++; $display("FAIL c1_plain got %h want %h", plainOut, C_PT); end
      tick();
   endtask

   task automatic test_back_pressure();
      int edges;
      int leaks;
      logic [127:0] held;
      out_ready = 1'b0;
      cipherIn = C_CT; key = C_KEY; in_valid = 1'b1;
      wait_valid(edges);
      held = plainOut;
      n_cmp++; if (edges !== 11 || held !== C_PT) begin n_bad++; $display("FAIL bp_result got lat=%0d %h want 11 %h", edges, held, C_PT); end
      cipherIn = B_CT; key = B_KEY;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || plainOut !== held || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold cycle %0d got v=%b r=%b %h want v=1 r=0 %h", i, out_valid, in_ready, plainOut, held);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
      n_cmp++; if (plainOut !== held) begin n_bad++; $display("FAIL bp_plain_retained got %h want %h", plainOut, held); end
      leaks = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (out_valid || !in_ready) leaks++;
      end
      n_cmp++; if (leaks !== 0) begin n_bad++; $display("FAIL bp_no_second_accept got %0d busy cycles want 0", leaks); end
   endtask

   task automatic test_reset_mid_op();
      int spurious;
      out_ready = 1'b1;
      cipherIn = B_CT; key = B_KEY; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (dut.rnd_q !== 4'd5) begin n_bad++; $display("FAIL mid_rnd got %0d want 5", dut.rnd_q); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) spurious++;
         tick();
      end
      n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL mid_abort_out_valid got %0d want 0", spurious); end
      n_cmp++; if (in_ready !== 1'b1 || plainOut !== 128'h0) begin n_bad++; $display("FAIL mid_idle got r=%b %h want r=1 0", in_ready, plainOut); end
      test_fips_c1();
   endtask

   task automatic test_back_to_back();
      int edges;
      out_ready = 1'b1;
      cipherIn = B_CT; key = B_KEY; in_valid = 1'b1;
      wait_valid(edges);
      n_cmp++; if (edges !== 11 || plainOut !== B_PT) begin n_bad++; $display("FAIL b2b_first got lat=%0d %h want 11 %h", edges, plainOut, B_PT); end
      cipherIn = C_CT; key = C_KEY;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_handshake got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept got r=%b want 0", in_ready); end
      in_valid = 1'b0;
      wait_valid(edges);
      n_cmp++; if (edges !== 10 || plainOut !== C_PT) begin n_bad++; $display("FAIL b2b_second got lat=%0d %h want 10 %h", edges, plainOut, C_PT); end
      tick();
   endtask

   initial begin
      test_reset();
      test_fips_b();
      test_fips_c1();
      test_back_pressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
